// File: rtl/mem_access_responder.sv
// Byte-serial memory access responder: turns 1/2/4-byte load/store tasks into single-byte
// RAM/IO bus cycles. Define MEM_RESP_IO_STALL_EN to stall IO-space writes on io_buffer_full.
module mem_access_responder #(
  parameter logic [31:0] IO_BASE = 32'h00030000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic        have_mem_access_task,
  input  logic [31:0] mem_access_addr,
  input  logic        mem_access_rw,
  input  logic [1:0]  mem_access_size,
  input  logic [31:0] mem_access_data,
  output logic        mem_access_task_done,
  output logic [31:0] mem_access_data_out,
  output logic        responder_idle,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] rbuf_q;
  logic [2:0]  cnt_q;
  logic [2:0]  len_q;

  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Next write byte to put on the bus. In IDLE this is byte 0 of the incoming task; in WRITE
  // it is the byte after the one on the bus, or the same byte again if it was held by a stall.
  logic [2:0]  wr_idx;
  logic [2:0]  wr_len;
  logic [31:0] wr_base;
  logic [31:0] wr_word;
  logic [31:0] wr_addr;
  logic [7:0]  wr_byte;
  logic        wr_last;
  logic        wr_stall;

  always_comb begin
    if (state_q == StIdle) begin
      wr_idx  = 3'd0;
      wr_base = mem_access_addr;
      wr_word = mem_access_data;
      wr_len  = size_to_len(mem_access_size);
    end else begin
      wr_idx  = mem_wr ? cnt_q + 3'd1 : cnt_q;
      wr_base = addr_q;
      wr_word = data_q;
      wr_len  = len_q;
    end
    wr_addr = wr_base + {29'd0, wr_idx};
    wr_byte = 8'(wr_word >> {wr_idx[1:0], 3'b000});
    wr_last = (wr_idx == wr_len - 3'd1);
  end

`ifdef MEM_RESP_IO_STALL_EN
  assign wr_stall = io_buffer_full && (wr_addr >= IO_BASE);
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign wr_stall = 1'b0;
`endif

  // mem_din carries the byte addressed in the previous cycle, so lane cnt_q-1 is captured now.
  logic [31:0] rd_word;
  always_comb begin
    rd_word = rbuf_q;
    case (cnt_q)
      3'd1:    rd_word[7:0]   = mem_din;
      3'd2:    rd_word[15:8]  = mem_din;
      3'd3:    rd_word[23:16] = mem_din;
      3'd4:    rd_word[31:24] = mem_din;
      default: ;
    endcase
  end

  assign responder_idle = (state_q == StIdle);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q              <= StIdle;
      addr_q               <= '0;
      data_q               <= '0;
      rbuf_q               <= '0;
      cnt_q                <= '0;
      len_q                <= '0;
      mem_access_task_done <= 1'b0;
      mem_access_data_out  <= '0;
      mem_dout             <= '0;
      mem_a                <= '0;
      mem_wr               <= 1'b0;
    end else if (rdy_in) begin
      unique case (state_q)
        StIdle: begin
          if (have_mem_access_task && !flush_pipline) begin
            addr_q              <= mem_access_addr;
            data_q              <= mem_access_data;
            len_q               <= size_to_len(mem_access_size);
            cnt_q               <= '0;
            rbuf_q              <= '0;
            mem_access_data_out <= '0;
            mem_a               <= mem_access_addr;
            if (mem_access_rw) begin
              mem_dout <= wr_byte;
              mem_wr   <= !wr_stall;
              if (!wr_stall && wr_last) begin
                mem_access_task_done <= 1'b1;
                state_q              <= StDone;
              end else begin
                state_q <= StWrite;
              end
            end else begin
              mem_dout <= '0;
              mem_wr   <= 1'b0;
              state_q  <= StRead;
            end
          end
        end
        StRead: begin
          if (flush_pipline) begin
            state_q <= StIdle;
            mem_a   <= '0;
            cnt_q   <= '0;
          end else begin
            rbuf_q <= rd_word;
            if (cnt_q == len_q) begin
              mem_access_data_out  <= rd_word;
              mem_access_task_done <= 1'b1;
              state_q              <= StDone;
            end else begin
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q < len_q - 3'd1) begin
                mem_a <= addr_q + {29'd0, cnt_q + 3'd1};
              end
            end
          end
        end
        StWrite: begin
          cnt_q    <= wr_idx;
          mem_a    <= wr_addr;
          mem_dout <= wr_byte;
          mem_wr   <= !wr_stall;
          if (!wr_stall && wr_last) begin
            mem_access_task_done <= 1'b1;
            state_q              <= StDone;
          end
        end
        StDone: begin
          mem_access_task_done <= 1'b0;
          mem_access_data_out  <= '0;
          mem_wr               <= 1'b0;
          cnt_q                <= '0;
          state_q              <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_responder.sv
// Randomised scoreboard bench for mem_access_responder with a byte-addressed reference memory.
// Expected IO-stall timing follows MEM_RESP_IO_STALL_EN when it is defined for the build.
module tb_mem_access_responder;

  localparam logic [31:0] IoBase = 32'h00030000;

  logic        clk = 1'b0;
  logic        rst_n, rdy, flush, have, rw, io_full;
  logic [31:0] addr, data;
  logic [1:0]  size;
  logic        task_done, idle, mem_wr;
  logic [31:0] data_out, mem_a;
  logic [7:0]  mem_din, mem_dout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mem_access_responder #(.IO_BASE(IoBase)) dut (
    .clk_in               (clk),
    .rst_in               (rst_n),
    .rdy_in               (rdy),
    .flush_pipline        (flush),
    .have_mem_access_task (have),
    .mem_access_addr      (addr),
    .mem_access_rw        (rw),
    .mem_access_size      (size),
    .mem_access_data      (data),
    .mem_access_task_done (task_done),
    .mem_access_data_out  (data_out),
    .responder_idle       (idle),
    .mem_din              (mem_din),
    .mem_dout             (mem_dout),
    .mem_a                (mem_a),
    .mem_wr               (mem_wr),
    .io_buffer_full       (io_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus-side RAM seen by the DUT, and the reference image the expectations come from.
  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram_rd(mem_a);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  logic prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (prev_done) check("done_width", task_done, 0);
      if (task_done) begin
        check("pending_expect", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("data_out", data_out, e.data);
          check("done_cycle", cyc, e.due);
        end
      end
    end
    prev_done = rst_n && task_done;
  end

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = idle;
    end
    if (!seen) check("idle_timeout", idle, 1);
  endtask

  // frz_at/frz_len: rdy low for frz_len edges from accept+frz_at. io_len: io_buffer_full high for
  // io_len edges from the accept edge. fl_at: one-edge flush at accept+fl_at (0 = none).
  task automatic run_task(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] d, input int frz_at, input int frz_len,
                          input int io_len, input int fl_at);
    int n, lat, acc, stall, k, e;
    logic [31:0] exp_val;
    logic done;
    exp_t x;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    wait_idle();
    exp_val = '0;
    if (!wr) for (int j = 0; j < n; j++) exp_val |= 32'(ref_rd(a + 32'(j))) << (8 * j);
    stall = 0;
`ifdef MEM_RESP_IO_STALL_EN
    if (wr && a >= IoBase) stall = io_len;
`endif
    lat = wr ? n - 1 + frz_len + stall : n + 1;
    have = 1'b1; rw = wr; addr = a; size = sz; data = d; io_full = (io_len > 0);
    @(posedge clk); #1;
    acc = cyc;
    x.data = wr ? 32'd0 : exp_val;
    x.due  = acc + lat;
    exp_q.push_back(x);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      k = cyc - acc;
      if (frz_len == 0 && stall == 0 && k < n) begin
        check("bus_addr", mem_a, a + 32'(k));
        check("bus_wr", mem_wr, wr);
        if (wr) check("bus_dout", mem_dout, 8'(d >> (8 * k)));
      end
      if (frz_len > 0 && k == frz_at + frz_len - 1) begin
        check("held_addr", mem_a, a + 32'(frz_at - 1));
        check("held_dout", mem_dout, 8'(d >> (8 * (frz_at - 1))));
      end
      if (stall > 0 && k < stall) check("stall_wr", mem_wr, 0);
      if (stall > 0 && k == stall) check("stall_release", mem_wr, 1);
      if (task_done) begin
        done = 1'b1;
        have = 1'b0;
      end
      e = cyc + 1 - acc;
      rdy = !(frz_len > 0 && e >= frz_at && e < frz_at + frz_len);
      io_full = (e < io_len);
      flush = (fl_at > 0 && e == fl_at);
    end
    if (!done) check("task_timeout", done, 1);
    rdy = 1'b1; io_full = 1'b0; flush = 1'b0; have = 1'b0;
    if (wr && done) for (int j = 0; j < n; j++) ref_mem[a + 32'(j)] = 8'(d >> (8 * j));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n, fa, fl, fat;
    logic        r_wr;
    logic [1:0]  r_sz;
    logic [31:0] r_a;
    int          region;

    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; have = 1'b0; rw = 1'b0; io_full = 1'b0;
    addr = '0; data = '0; size = '0;

    repeat (3) @(negedge clk);
    check("rst_done", task_done, 0);
    check("rst_data_out", data_out, 0);
    check("rst_idle", idle, 1);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_dout", mem_dout, 0);
    rst_n = 1'b1;

    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    ref_mem[32'h100] = 8'h11; ref_mem[32'h101] = 8'h22;
    ref_mem[32'h102] = 8'h33; ref_mem[32'h103] = 8'h44;
    ram[32'h7] = 8'h80; ref_mem[32'h7] = 8'h80;

    run_task(1'b0, 32'h100, 2'b10, 32'h0, 0, 0, 0, 0);          // word read -> 44332211
    run_task(1'b1, 32'h202, 2'b01, 32'hDEADBEEF, 0, 0, 0, 0);   // half write
    run_task(1'b0, 32'h202, 2'b01, 32'h0, 0, 0, 0, 0);
    run_task(1'b0, 32'h204, 2'b00, 32'h0, 0, 0, 0, 0);          // neighbour untouched
    run_task(1'b0, 32'h7, 2'b00, 32'h0, 0, 0, 0, 0);            // zero-extended byte
    run_task(1'b0, 32'h103, 2'b11, 32'h0, 0, 0, 0, 0);          // size 11 acts as word

    // Flush mid-read: no completion, back to idle with the address cleared.
    wait_idle();
    have = 1'b1; rw = 1'b0; addr = 32'h100; size = 2'b10;
    @(posedge clk); #1;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1; have = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", idle, 1);
    check("flush_mem_a", mem_a, 0);
    repeat (4) @(negedge clk);
    run_task(1'b0, 32'h10, 2'b10, 32'h0, 0, 0, 0, 0);

    // Flush in IDLE beats a simultaneous request.
    wait_idle();
    have = 1'b1; rw = 1'b0; addr = 32'h20; size = 2'b00; flush = 1'b1;
    @(negedge clk);
    check("flush_blocks_accept", idle, 1);
    have = 1'b0; flush = 1'b0;

    run_task(1'b1, 32'h300, 2'b10, 32'hCAFEF00D, 2, 3, 0, 0);   // rdy low 3 cycles
    run_task(1'b0, 32'h300, 2'b10, 32'h0, 0, 0, 0, 0);
    run_task(1'b1, IoBase, 2'b00, 32'h000000A5, 0, 0, 4, 0);     // io_buffer_full 4 cycles
    run_task(1'b1, 32'hFFFFFFFE, 2'b10, 32'h01020304, 0, 0, 0, 0);
    run_task(1'b0, 32'hFFFFFFFE, 2'b10, 32'h0, 0, 0, 0, 0);
    run_task(1'b1, 32'h340, 2'b10, 32'h55667788, 0, 0, 0, 2);    // flush ignored in write

    for (int i = 0; i < 40; i++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_sz = 2'($urandom_range(0, 3));
      region = $urandom_range(0, 2);
      r_a = (region == 0) ? 32'h400 + 32'($urandom_range(0, 63)) :
            (region == 1) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) :
                            IoBase - 32'd4 + 32'($urandom_range(0, 15));
      n = (r_sz == 2'd0) ? 1 : (r_sz == 2'd1) ? 2 : 4;
      fa = 0; fl = 0; fat = 0;
      if (r_wr && n > 1 && $urandom_range(0, 2) == 0) begin
        fa = $urandom_range(1, n - 1);
        fl = $urandom_range(1, 3);
      end
      if (r_wr && $urandom_range(0, 3) == 0) fat = $urandom_range(1, n);
      run_task(r_wr, r_a, r_sz, $urandom, fa, fl, 0, fat);
    end

    // Reset mid-write: the first two bytes already reached RAM, the rest never do.
    wait_idle();
    have = 1'b1; rw = 1'b1; addr = 32'h500; size = 2'b10; data = 32'hA1B2C3D4;
    @(posedge clk); #1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; have = 1'b0;
    #1;
    check("midrst_idle", idle, 1);
    check("midrst_mem_wr", mem_wr, 0);
    check("midrst_done", task_done, 0);
    check("midrst_mem_a", mem_a, 0);
    ref_mem[32'h500] = 8'hD4;
    ref_mem[32'h501] = 8'hC3;
    @(negedge clk);
    rst_n = 1'b1;
    run_task(1'b0, 32'h500, 2'b10, 32'h0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("leftover_expect", exp_q.size(), 0);
    foreach (ref_mem[a]) check("ram_byte", ram_rd(a), ref_mem[a]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
